// File: rtl/recip_sched.sv
// Round-robin scheduler that shares one iterative reciprocal unit among N requesters.
// Every calculation is bounded by TIMEOUT cycles, and the tagged response is returned to the winning requester.
module recip_sched #(
  parameter  int N       = 4,
  parameter  int W       = 32,
  parameter  int TIMEOUT = 32,
  localparam int IW      = (N > 1) ? $clog2(N) : 1,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_x,
  output logic [N-1:0]   ack,
  output logic           calc_start,
  output logic [W-1:0]   calc_x,
  input  logic           calc_done,
  input  logic [W-1:0]   calc_result,
  input  logic           calc_invalid,
  output logic           rsp_valid,
  output logic [IW-1:0]  rsp_id,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_invalid,
  output logic           rsp_timeout,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP, DRAIN} state_t;

  state_t        r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_id;
  logic [W-1:0]  r_op;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_ack;
  logic          r_start;
  logic          r_rsp_valid;
  logic [W-1:0]  r_rsp_data;
  logic          r_rsp_invalid;
  logic          r_rsp_timeout;

  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_ptr_next;

  // Scan downwards so the last hit is the requester closest to ptr.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = IW'((int'(r_ptr) + k) % N);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_next = (r_id == IW'(N - 1)) ? '0 : r_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_id          <= '0;
      r_op          <= '0;
      r_cnt         <= '0;
      r_ack         <= '0;
      r_start       <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_invalid <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_ack       <= '0;
      r_start     <= 1'b0;
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_op    <= req_x[w_win*W +: W];
            r_id    <= w_win;
            r_ack   <= {{(N-1){1'b0}}, 1'b1} << w_win;
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // A done arriving on the last allowed cycle still wins over the timeout.
          if (calc_done) begin
            r_rsp_data    <= calc_result;
            r_rsp_invalid <= calc_invalid;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_rsp_data    <= '0;
            r_rsp_invalid <= 1'b0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= DRAIN;
          end
        end
        RESP: begin
          r_ptr   <= w_ptr_next;
          r_state <= IDLE;
        end
        DRAIN: begin
          // Hold off new grants until the unit finishes the abandoned calculation.
          r_ptr <= w_ptr_next;
          if (calc_done) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack         = r_ack;
  assign calc_start  = r_start;
  assign calc_x      = r_op;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_invalid = r_rsp_invalid;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = (r_state != IDLE);

endmodule
